// File: rtl/vfm_asm2ir_pkg.sv
// Shared constants and helpers for the VFM streaming assembler: FSM states,
// ASCII codes, opcodes, JUMP condition codes and small character predicates.
package vfm_asm2ir_pkg;

    typedef enum logic [2:0] {S_IDLE, S_MNEM, S_OPND, S_EMIT, S_ERR} state_t;

    localparam logic [7:0] CH_SEMI = 8'h3B, CH_LF = 8'h0A, CH_CR = 8'h0D,
                           CH_SP   = 8'h20, CH_COMMA = 8'h2C;

    localparam logic [15:0] STALL_IW = 16'hFFFF;

    localparam logic [5:0]
        OP_LD   = 6'h00, OP_ST   = 6'h01, OP_CPY  = 6'h02, OP_SWAP = 6'h03,
        OP_JUMP = 6'h04, OP_ADD  = 6'h05, OP_SUB  = 6'h06, OP_ADDC = 6'h07,
        OP_SUBC = 6'h08, OP_NOT  = 6'h09, OP_AND  = 6'h0A, OP_OR   = 6'h0B,
        OP_SRA  = 6'h0C, OP_RRC  = 6'h0D, OP_VADD = 6'h0E, OP_VSUB = 6'h0F,
        OP_MUL  = 6'h10, OP_DIV  = 6'h11, OP_XOR  = 6'h12, OP_SHRL = 6'h13,
        OP_SHRA = 6'h14, OP_ROTL = 6'h15, OP_ROTR = 6'h16, OP_RLN  = 6'h17,
        OP_RLZ  = 6'h18, OP_RRN  = 6'h19, OP_RRZ  = 6'h1A, OP_CALL = 6'h1B,
        OP_RET  = 6'h1C, OP_IN   = 6'h1D, OP_OUT  = 6'h1E, OP_VADDC = 6'h20,
        OP_VSUBC = 6'h21, OP_CMP = 6'h30, OP_NOP  = 6'h38;

    localparam logic [4:0]
        JC_U  = 5'b00000, JC_C1 = 5'b10000, JC_N1 = 5'b01000, JC_V1 = 5'b00100,
        JC_Z1 = 5'b00010, JC_C0 = 5'b01110, JC_N0 = 5'b10110, JC_V0 = 5'b11010,
        JC_Z0 = 5'b11100;

    typedef struct packed {
        logic       hit;
        logic       is_stall;
        logic       is_jump;
        logic       is_ldst;
        logic [5:0] opcode;
    } lut_res_t;

    function automatic logic f_is_letter(input logic [7:0] c);
        return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
    endfunction

    function automatic logic [7:0] f_upcase(input logic [7:0] c);
        return (c >= "a" && c <= "z") ? (c & 8'hDF) : c;
    endfunction

    function automatic logic f_is_digit(input logic [7:0] c);
        return c >= "0" && c <= "9";
    endfunction

    function automatic logic f_is_term(input logic [7:0] c);
        return c == CH_SEMI || c == CH_LF;
    endfunction

    // Separators and register/address prefixes that carry no meaning in operands
    function automatic logic f_is_opnd_sep(input logic [7:0] c);
        return c == CH_SP || c == CH_CR || c == CH_COMMA || c == "R" || c == "#" ||
               c == "M"   || c == "A"   || c == "r"      || c == "=";
    endfunction

    function automatic logic f_is_cond(input logic [7:0] c);
        return c == "U" || c == "C" || c == "N" || c == "V" || c == "Z";
    endfunction

    // Returns {ok, code}; an absent token means unconditional
    function automatic logic [5:0] f_jump_code(input logic lv, input logic [7:0] ltr,
                                               input logic dv, input logic d);
        logic [5:0] r;
        r = 6'b0;
        if (!lv) r = {1'b1, JC_U};
        else begin
            case (ltr)
                "U":     r = {!dv, JC_U};
                "C":     r = {dv, d ? JC_C1 : JC_C0};
                "N":     r = {dv, d ? JC_N1 : JC_N0};
                "V":     r = {dv, d ? JC_V1 : JC_V0};
                "Z":     r = {dv, d ? JC_Z1 : JC_Z0};
                default: r = 6'b0;
            endcase
        end
        return r;
    endfunction

    // Field placement mirrors the disassembly text
    function automatic logic [15:0] f_build_iw(input lut_res_t m, input logic [4:0] op1,
                                               input logic [4:0] op2, input logic [4:0] jc);
        logic [15:0] w;
        if (m.is_stall)     w = STALL_IW;
        else if (m.is_jump) w = {m.opcode, 5'd0, jc};
        else if (m.is_ldst) w = {m.opcode, op2, op1};
        else                w = {m.opcode, op1, op2};
        return w;
    endfunction

endpackage

// File: rtl/vfm_asm_mnem_lut.sv
// Combinational mnemonic matcher: 40-bit right-aligned, upper-case text in,
// opcode and class flags out.
module vfm_asm_mnem_lut
    import vfm_asm2ir_pkg::*;
(
    input  logic [39:0] mnem,
    output lut_res_t    res
);

    // Exact match against every legal mnemonic; anything else is a miss
    always_comb begin
        res     = '0;
        res.hit = 1'b1;
        case (mnem)
            {24'd0, "LD"}:   begin res.opcode = OP_LD; res.is_ldst = 1'b1; end
            {24'd0, "ST"}:   begin res.opcode = OP_ST; res.is_ldst = 1'b1; end
            {16'd0, "CPY"}:  res.opcode = OP_CPY;
            {8'd0,  "SWAP"}: res.opcode = OP_SWAP;
            {8'd0,  "JUMP"}: begin res.opcode = OP_JUMP; res.is_jump = 1'b1; end
            {16'd0, "ADD"}:  res.opcode = OP_ADD;
            {16'd0, "SUB"}:  res.opcode = OP_SUB;
            {8'd0,  "ADDC"}: res.opcode = OP_ADDC;
            {8'd0,  "SUBC"}: res.opcode = OP_SUBC;
            {16'd0, "NOT"}:  res.opcode = OP_NOT;
            {16'd0, "AND"}:  res.opcode = OP_AND;
            {24'd0, "OR"}:   res.opcode = OP_OR;
            {16'd0, "SRA"}:  res.opcode = OP_SRA;
            {16'd0, "RRC"}:  res.opcode = OP_RRC;
            {8'd0,  "VADD"}: res.opcode = OP_VADD;
            {8'd0,  "VSUB"}: res.opcode = OP_VSUB;
            {16'd0, "MUL"}:  res.opcode = OP_MUL;
            {16'd0, "DIV"}:  res.opcode = OP_DIV;
            {16'd0, "XOR"}:  res.opcode = OP_XOR;
            {8'd0,  "SHRL"}: res.opcode = OP_SHRL;
            {8'd0,  "SHRA"}: res.opcode = OP_SHRA;
            {8'd0,  "ROTL"}: res.opcode = OP_ROTL;
            {8'd0,  "ROTR"}: res.opcode = OP_ROTR;
            {16'd0, "RLN"}:  res.opcode = OP_RLN;
            {16'd0, "RLZ"}:  res.opcode = OP_RLZ;
            {16'd0, "RRN"}:  res.opcode = OP_RRN;
            {16'd0, "RRZ"}:  res.opcode = OP_RRZ;
            {8'd0,  "CALL"}: res.opcode = OP_CALL;
            {16'd0, "RET"}:  res.opcode = OP_RET;
            {24'd0, "IN"}:   res.opcode = OP_IN;
            {16'd0, "OUT"}:  res.opcode = OP_OUT;
            "VADDC":         res.opcode = OP_VADDC;
            "VSUBC":         res.opcode = OP_VSUBC;
            {16'd0, "CMP"}:  res.opcode = OP_CMP;
            {16'd0, "NOP"}:  res.opcode = OP_NOP;
            "STALL":         res.is_stall = 1'b1;
            default:         res.hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/vfm_asm2ir.sv
// Streaming assembler top: one ASCII character per cycle in, one encoded
// 16-bit instruction word out per terminated statement.
module vfm_asm2ir
    import vfm_asm2ir_pkg::*;
(
    input  logic        Clock_pin,
    input  logic        Resetn_pin,
    input  logic [7:0]  Char_in,
    input  logic        Char_valid,
    output logic        Char_ready,
    output logic [15:0] IW_out,
    output logic        IW_valid,
    input  logic        IW_ready,
    output logic        Asm_err
);

    state_t      state_q, state_d;
    logic [39:0] mnem_q, mnem_d;
    logic [2:0]  mcnt_q, mcnt_d;
    lut_res_t    info_q, info_d, lut;
    logic [4:0]  op1_q, op1_d, op2_q, op2_d;
    logic [6:0]  acc_q, acc_d, acc_nxt;
    logic [1:0]  ocnt_q, ocnt_d;
    logic        innum_q, innum_d, dig2_q, dig2_d;
    logic        jlv_q, jlv_d, jdv_q, jdv_d, jd_q, jd_d;
    logic [7:0]  jl_q, jl_d;
    logic [15:0] iw_q, iw_d;
    logic        err_q, err_d;
    logic        take, term;
    logic [7:0]  uc;
    logic [3:0]  dig;
    logic [5:0]  jc;

    vfm_asm_mnem_lut u_lut (.mnem(mnem_q), .res(lut));

    assign Char_ready = (state_q != S_EMIT);
    assign IW_valid   = (state_q == S_EMIT);
    assign IW_out     = iw_q;
    assign Asm_err    = err_q;

    assign take    = Char_valid && Char_ready;
    assign term    = f_is_term(Char_in);
    assign uc      = f_upcase(Char_in);
    assign dig     = Char_in[3:0];
    assign acc_nxt = acc_q * 7'd10 + {3'd0, dig};
    assign jc      = f_jump_code(jlv_q, jl_q, jdv_q, jd_q);

    // Parse FSM: tokenise characters, accumulate operands, build the IW
    always_comb begin
        state_d = state_q;  mnem_d = mnem_q;   mcnt_d = mcnt_q;  info_d = info_q;
        op1_d   = op1_q;    op2_d  = op2_q;    acc_d  = acc_q;   ocnt_d = ocnt_q;
        innum_d = innum_q;  dig2_d = dig2_q;   jlv_d  = jlv_q;   jl_d   = jl_q;
        jdv_d   = jdv_q;    jd_d   = jd_q;     iw_d   = iw_q;    err_d  = 1'b0;
        case (state_q)
            S_IDLE: if (take) begin
                if (f_is_letter(Char_in)) begin
                    mnem_d  = {32'd0, uc};
                    mcnt_d  = 3'd1;
                    op1_d   = 5'd0;  op2_d  = 5'd0;  acc_d = 7'd0;  ocnt_d = 2'd0;
                    innum_d = 1'b0;  dig2_d = 1'b0;
                    jlv_d   = 1'b0;  jl_d   = 8'd0;  jdv_d = 1'b0;  jd_d   = 1'b0;
                    state_d = S_MNEM;
                end else if (!(term || Char_in == CH_SP || Char_in == CH_CR)) begin
                    state_d = S_ERR;
                end
            end
            S_MNEM: if (take) begin
                if (f_is_letter(Char_in)) begin
                    if (mcnt_q == 3'd5) state_d = S_ERR;
                    else begin
                        mnem_d = {mnem_q[31:0], uc};
                        mcnt_d = mcnt_q + 3'd1;
                    end
                end else if (term || Char_in == CH_SP || Char_in == CH_CR ||
                             Char_in == CH_COMMA) begin
                    if (!lut.hit) begin
                        // a miss on the terminator closes the statement at once
                        err_d   = term;
                        state_d = term ? S_IDLE : S_ERR;
                    end else begin
                        info_d = lut;
                        if (term) begin
                            iw_d    = f_build_iw(lut, 5'd0, 5'd0, JC_U);
                            state_d = S_EMIT;
                        end else state_d = S_OPND;
                    end
                end else state_d = S_ERR;
            end
            S_OPND: if (take) begin
                if (term) begin
                    if (info_q.is_jump && !jc[5]) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        iw_d    = f_build_iw(info_q, op1_q, op2_q, jc[4:0]);
                        state_d = S_EMIT;
                    end
                end else if (info_q.is_stall) begin
                    // STALL ignores whatever follows it
                end else if (f_is_opnd_sep(Char_in)) begin
                    innum_d = 1'b0;
                end else if (info_q.is_jump) begin
                    if (f_is_cond(uc) && !jlv_q) begin
                        jlv_d = 1'b1;
                        jl_d  = uc;
                    end else if ((Char_in == "0" || Char_in == "1") && jlv_q && !jdv_q) begin
                        jdv_d = 1'b1;
                        jd_d  = Char_in[0];
                    end else state_d = S_ERR;
                end else if (f_is_digit(Char_in)) begin
                    if (!innum_q) begin
                        if (ocnt_q == 2'd2) state_d = S_ERR;
                        else begin
                            innum_d = 1'b1;
                            dig2_d  = 1'b0;
                            acc_d   = {3'd0, dig};
                            ocnt_d  = ocnt_q + 2'd1;
                            if (ocnt_q == 2'd0) op1_d = {1'b0, dig};
                            else                op2_d = {1'b0, dig};
                        end
                    end else if (dig2_q || acc_nxt > 7'd31) begin
                        state_d = S_ERR;
                    end else begin
                        dig2_d = 1'b1;
                        acc_d  = acc_nxt;
                        if (ocnt_q == 2'd1) op1_d = acc_nxt[4:0];
                        else                op2_d = acc_nxt[4:0];
                    end
                end else state_d = S_ERR;
            end
            S_EMIT: if (IW_ready) state_d = S_IDLE;
            S_ERR: if (take && term) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any partial or pending statement
    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            state_q <= S_IDLE;  mnem_q <= '0;  mcnt_q <= '0;  info_q <= '0;
            op1_q   <= '0;      op2_q  <= '0;  acc_q  <= '0;  ocnt_q <= '0;
            innum_q <= 1'b0;    dig2_q <= 1'b0;
            jlv_q   <= 1'b0;    jl_q   <= '0;  jdv_q  <= 1'b0; jd_q  <= 1'b0;
            iw_q    <= '0;      err_q  <= 1'b0;
        end else begin
            state_q <= state_d; mnem_q <= mnem_d; mcnt_q <= mcnt_d; info_q <= info_d;
            op1_q   <= op1_d;   op2_q  <= op2_d;  acc_q  <= acc_d;  ocnt_q <= ocnt_d;
            innum_q <= innum_d; dig2_q <= dig2_d;
            jlv_q   <= jlv_d;   jl_q   <= jl_d;   jdv_q  <= jdv_d;  jd_q   <= jd_d;
            iw_q    <= iw_d;    err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_vfm_asm2ir.sv
// Bench for vfm_asm2ir: a table of statements with hand-computed words,
// plus hand-written sequences for latency, backpressure, error pulse and reset.
module tb_vfm_asm2ir;

    logic        Clock_pin = 1'b0;
    logic        Resetn_pin;
    logic [7:0]  Char_in;
    logic        Char_valid;
    logic        Char_ready;
    logic [15:0] IW_out;
    logic        IW_valid;
    logic        IW_ready;
    logic        Asm_err;

    int total = 0;
    int bad   = 0;
    int iw_cnt = 0;
    int err_cnt = 0;
    logic [15:0] last_iw = 16'h0;

    typedef struct {
        string       txt;
        int          n_iw;
        logic [15:0] iw;
        int          n_err;
    } vec_t;
    vec_t vecs[$];

    vfm_asm2ir dut (
        .Clock_pin (Clock_pin),  .Resetn_pin(Resetn_pin),
        .Char_in   (Char_in),    .Char_valid(Char_valid), .Char_ready(Char_ready),
        .IW_out    (IW_out),     .IW_valid  (IW_valid),   .IW_ready  (IW_ready),
        .Asm_err   (Asm_err)
    );

    always #5 Clock_pin = ~Clock_pin;

    // Count IW transfers and Asm_err-high cycles away from the active edge
    always @(negedge Clock_pin) begin
        if (IW_valid && IW_ready) begin
            iw_cnt  <= iw_cnt + 1;
            last_iw <= IW_out;
        end
        if (Asm_err) err_cnt <= err_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string t, input int n, input logic [15:0] w, input int e);
        vec_t v;
        v.txt = t; v.n_iw = n; v.iw = w; v.n_err = e;
        vecs.push_back(v);
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance
    task automatic send_char(input logic [7:0] c);
        logic r;
        r = 1'b0;
        Char_in    = c;
        Char_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clock_pin);
            r = Char_ready;
            @(posedge Clock_pin);
            #1;
            if (r) break;
        end
        Char_valid = 1'b0;
        if (!r) begin
            total++;
            bad++;
            $display("FAIL char_accept: char 0x%0h not accepted within 20 cycles", c);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic step();
        @(posedge Clock_pin);
        #1;
    endtask

    initial begin
        int b_iw, b_err;
        Resetn_pin = 1'b0;
        Char_in    = 8'h0;
        Char_valid = 1'b0;
        IW_ready   = 1'b1;

        add_vec("ADD R3, R4;",      1, 16'h1464, 0);
        add_vec("LD R3, MAr5;",     1, 16'h00A3, 0);
        add_vec("JUMP Z=0;",        1, 16'h101C, 0);
        add_vec("STALL;",           1, 16'hFFFF, 0);
        add_vec("FOO R1;",          0, 16'h0000, 1);
        add_vec("ADD R40, R1;",     0, 16'h0000, 1);
        add_vec("NOT R2;",          1, 16'h2440, 0);
        add_vec("add r1,r2\n;;",    1, 16'h1422, 0);
        add_vec("JUMP C1;",         1, 16'h1010, 0);
        add_vec("JUMP U;",          1, 16'h1000, 0);
        add_vec("JUMP;",            1, 16'h1000, 0);
        add_vec("JUMP N0;",         1, 16'h1016, 0);
        add_vec("JUMP C;",          0, 16'h0000, 1);
        add_vec("JUMP X1;",         0, 16'h0000, 1);
        add_vec("ADD R1, R2, R3;",  0, 16'h0000, 1);
        add_vec("ADD R123;",        0, 16'h0000, 1);
        add_vec("ADD R32;",         0, 16'h0000, 1);
        add_vec("ADDCXY;",          0, 16'h0000, 1);
        add_vec("ADD R3 ! ;",       0, 16'h0000, 1);
        add_vec("VADDC R31, R0;",   1, 16'h83E0, 0);
        add_vec("ST R1, R2;",       1, 16'h0441, 0);
        add_vec("CMP R7\n",         1, 16'hC0E0, 0);
        add_vec("NOP;",             1, 16'hE000, 0);
        add_vec("STALL R3, R9;",    1, 16'hFFFF, 0);
        add_vec("SHRA R10, R5;",    1, 16'h5145, 0);
        add_vec("RET;",             1, 16'h7000, 0);

        // Reset state
        repeat (3) step();
        @(negedge Clock_pin);
        chk("rst_iw_out",     32'(IW_out),     32'h0);
        chk("rst_iw_valid",   32'(IW_valid),   32'h0);
        chk("rst_asm_err",    32'(Asm_err),    32'h0);
        chk("rst_char_ready", 32'(Char_ready), 32'h1);
        step();
        Resetn_pin = 1'b1;
        step();

        // Table-driven statements with the consumer always ready
        foreach (vecs[i]) begin
            b_iw  = iw_cnt;
            b_err = err_cnt;
            send_str(vecs[i].txt);
            repeat (3) step();
            chk($sformatf("v%0d_n_iw", i),  32'(iw_cnt - b_iw),   32'(vecs[i].n_iw));
            chk($sformatf("v%0d_n_err", i), 32'(err_cnt - b_err), 32'(vecs[i].n_err));
            if (vecs[i].n_iw == 1)
                chk($sformatf("v%0d_iw", i), 32'(last_iw), 32'(vecs[i].iw));
        end

        // First-word latency: IW_valid with final word one cycle after ';'
        send_str("ADD R3, R4;");
        @(negedge Clock_pin);
        chk("lat_valid",      32'(IW_valid),   32'h1);
        chk("lat_iw",         32'(IW_out),     32'h1464);
        chk("lat_char_ready", 32'(Char_ready), 32'h0);
        step();
        @(negedge Clock_pin);
        chk("lat_valid_drop", 32'(IW_valid),   32'h0);
        chk("lat_ready_back", 32'(Char_ready), 32'h1);
        step();

        // Backpressure: RET held for 3 cycles, transfer on the 4th
        IW_ready = 1'b0;
        send_str("RET;");
        for (int k = 0; k < 3; k++) begin
            @(negedge Clock_pin);
            chk($sformatf("bp%0d_valid", k), 32'(IW_valid),   32'h1);
            chk($sformatf("bp%0d_iw", k),    32'(IW_out),     32'h7000);
            chk($sformatf("bp%0d_cready", k), 32'(Char_ready), 32'h0);
            step();
        end
        IW_ready = 1'b1;
        b_iw = iw_cnt;
        @(negedge Clock_pin);
        chk("bp3_valid", 32'(IW_valid), 32'h1);
        chk("bp3_iw",    32'(IW_out),   32'h7000);
        step();
        @(negedge Clock_pin);
        chk("bp_done_valid",  32'(IW_valid),       32'h0);
        chk("bp_done_cready", 32'(Char_ready),     32'h1);
        chk("bp_xfer_count",  32'(iw_cnt - b_iw),  32'h1);
        step();

        // Error pulse timing: exactly one cycle, right after ';'
        send_str("FOO R1;");
        @(negedge Clock_pin);
        chk("err_pulse_hi",    32'(Asm_err),  32'h1);
        chk("err_no_valid",    32'(IW_valid), 32'h0);
        step();
        @(negedge Clock_pin);
        chk("err_pulse_lo",    32'(Asm_err),  32'h0);
        step();
        send_str("NOT R2;");
        @(negedge Clock_pin);
        chk("after_err_valid", 32'(IW_valid), 32'h1);
        chk("after_err_iw",    32'(IW_out),   32'h2440);
        step();

        // Reset mid-statement discards the partial SUB
        b_iw = iw_cnt;
        send_str("SUB R1");
        Resetn_pin = 1'b0;
        step();
        @(negedge Clock_pin);
        chk("rst_mid_valid",  32'(IW_valid),   32'h0);
        chk("rst_mid_cready", 32'(Char_ready), 32'h1);
        step();
        Resetn_pin = 1'b1;
        step();
        send_str("OR R5, R6;");
        @(negedge Clock_pin);
        chk("rst_mid_or_valid", 32'(IW_valid), 32'h1);
        chk("rst_mid_or_iw",    32'(IW_out),   32'h2CA6);
        repeat (2) step();
        chk("rst_mid_count", 32'(iw_cnt - b_iw), 32'h1);

        // Reset while a word is pending in EMIT drops it
        IW_ready = 1'b0;
        send_str("NOP;");
        @(negedge Clock_pin);
        chk("rst_emit_pending", 32'(IW_valid), 32'h1);
        step();
        Resetn_pin = 1'b0;
        @(negedge Clock_pin);
        chk("rst_emit_valid", 32'(IW_valid), 32'h0);
        chk("rst_emit_iw",    32'(IW_out),   32'h0);
        step();
        IW_ready   = 1'b1;
        Resetn_pin = 1'b1;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
